// File: rtl/neuron_mac_sequencer.sv
// Sequencer and requantiser for one fully-connected neuron.
// Drives the MAC, adds bias, applies ReLU, shifts and saturates.
module neuron_mac_sequencer #(
  parameter int WIDTH           = 8,
  parameter int input_data_size = 784,
  parameter int FRAC_BITS       = 6,
  localparam int AW  = (input_data_size > 1) ?
                       $clog2(input_data_size) : 1,
  localparam int ACC_WIDTH = 2*WIDTH +
                             $clog2(input_data_size) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [2*WIDTH-1:0]     bias,
  output logic [AW-1:0]          mem_addr,
  output logic                   mac_clken,
  output logic                   mac_sload,
  output logic                   mac_aclr,
  input  logic [ACC_WIDTH-1:0]   mac_result,
  output logic                   busy,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid
);

  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] QMAX =
    SW'((2**(WIDTH-1)) - 1);
  localparam logic signed [SW-1:0] QMIN = ~QMAX;
  localparam logic [AW-1:0] KLAST =
    AW'(input_data_size - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, ACCUM, POST, DONE
  } state_t;

  state_t state, state_n;
  logic [AW-1:0] k, k_n;
  logic [WIDTH-1:0] out_n;
  logic last;

  logic signed [SW-1:0] s_sum;
  logic signed [SW-1:0] s_relu;
  logic signed [SW-1:0] q;
  logic [WIDTH-1:0]     q_sat;

  assign last = (k == KLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      out_data <= '0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      out_data <= out_n;
    end
  end

  // One extra bit over the accumulator absorbs the bias add
  always_comb begin
    s_sum = {{(SW-ACC_WIDTH){mac_result[ACC_WIDTH-1]}},
             mac_result} +
            {{(SW-2*WIDTH){bias[2*WIDTH-1]}}, bias};
    s_relu = (relu_en && s_sum[SW-1]) ? '0 : s_sum;
    q = s_relu >>> FRAC_BITS;
    if (q > QMAX)
      q_sat = QMAX[WIDTH-1:0];
    else if (q < QMIN)
      q_sat = QMIN[WIDTH-1:0];
    else
      q_sat = q[WIDTH-1:0];
  end

  always_comb begin
    state_n   = state;
    k_n       = k;
    out_n     = out_data;
    mem_addr  = '0;
    mac_clken = 1'b0;
    mac_sload = 1'b0;
    mac_aclr  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        mac_aclr = 1'b1;
        k_n      = '0;
        if (start) state_n = FETCH;
      end
      FETCH: begin
        k_n     = '0;
        state_n = ACCUM;
      end
      ACCUM: begin
        mac_clken = 1'b1;
        mac_sload = (k == '0);
        // Address runs one term ahead of the MAC
        mem_addr  = last ? k : k + AW'(1);
        if (last) state_n = POST;
        else      k_n     = k + AW'(1);
      end
      POST: begin
        out_n   = q_sat;
        state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
Control and post-processing stage for one neuron of the fully-connected layer. It drives the signed multiply-accumulate unit: it steps the input and weight memory addresses, generates the MAC's clken, sload and aclr, and waits for the MAC's accumulated sum. It then adds the bias, applies optional ReLU, rescales and saturates the result back to WIDTH bits. The output is presented with a one-cycle valid strobe to the next layer's input buffer.

Parameters:
WIDTH, 8, bit width of activations, weights and out_data (signed).
input_data_size, 784, number of MAC terms per neuron (N); must be at least 1.
FRAC_BITS, 6, arithmetic right-shift applied after the bias add for requantisation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to compute one neuron; sampled only in IDLE.
relu_en  input  1  1 = clamp negative results to 0; sampled in POST.
bias  input  2*WIDTH  signed bias in product scale; must be held stable from start until out_valid.
mem_addr  output  max(1,$clog2(input_data_size))  shared read address to the activation and weight memories (synchronous read, 1-cycle latency).
mac_clken  output  1  MAC clock enable.
mac_sload  output  1  MAC restart: the accumulator loads the product instead of adding it.
mac_aclr  output  1  MAC clear (synchronous in MAC).
mac_result  input  2*WIDTH+$clog2(input_data_size)+1  signed accumulator output from the MAC.
busy  output  1  high whenever state != IDLE.
out_data  output  WIDTH  signed requantised neuron output; held until the next POST.
out_valid  output  1  one-cycle strobe, out_data is valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, address counter=0, mem_addr=0.
  - mac_clken=0, mac_sload=0, out_valid=0, out_data=0, busy=0.
  - mac_aclr=1.
  - Reset takes effect immediately from any state, including mid-ACCUM.
- States: IDLE, FETCH, ACCUM, POST, DONE. Let cycle 0 be the cycle start=1 is sampled in IDLE.
- IDLE: mac_aclr=1, mac_clken=0. start=1 -> FETCH. start while not IDLE is ignored (no queueing).
- FETCH (cycle 1): mem_addr=0, mac_aclr=0. Next state is ACCUM with k=0.
- ACCUM (cycles 2..N+1, k=0..N-1):
  - mac_clken=1; mac_sload=1 only when k=0.
  - mem_addr=k+1, saturating at N-1 (a don't-care read).
  - After k=N-1 -> POST. For N=1, ACCUM lasts exactly one cycle.
- POST (cycle N+2): mac_clken=0; mac_result now holds sum(x[i]*w[i]). Compute:
  - s = mac_result + sign-extended bias, at width ACC_WIDTH+1 so there is no overflow.
  - If relu_en and s<0, then s=0.
  - q = s >>> FRAC_BITS (arithmetic shift, floor).
  - Saturate q to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register q into out_data at the end of POST; next state DONE.
- DONE (cycle N+3): out_valid=1 for exactly one cycle, busy=1. Next state IDLE. The earliest next start is cycle N+4.
- Latency: start to out_valid is N+3 cycles. Throughput is one neuron per N+4 cycles.
- mac_sload on k=0 guarantees no stale accumulator contribution, even after a mid-operation reset.
- mac_aclr is never asserted in the same cycle as mac_clken.

Test Plan:
(N=4, WIDTH=8, FRAC_BITS=6; bench instantiates the real MAC plus 1-cycle-latency memory models.)
1. x={64,64,64,64}, w={16,16,16,16}, bias=0, relu_en=0, start at cycle 0 -> mem_addr sequence 0,1,2,3,3; mac_sload high only in cycle 2; out_valid only in cycle 7 with out_data=64; busy high in cycles 1..7.
2. Same data with w={-16,...}: relu_en=0 -> out_data=-64; relu_en=1 -> out_data=0.
3. x={127,...}, w={-128,...}, relu_en=0 -> sum -65024, q=-1016, out_data=-128 (saturate low). x={127,...}, w={127,...} -> out_data=127 (saturate high).
4. Rounding and bias: a sum of 100 with bias 0 -> out_data=1. A sum of 4096 with bias=-4160 -> s=-64, out_data=-1 (relu_en=0); a sum of -100 -> out_data=-2 (floor).
5. start pulsed in cycles 3 and 7 -> ignored, no extra out_valid. start in cycle 8 -> second result valid in cycle 15 with no contamination from the first sum.
6. rst_n=0 for one cycle during ACCUM k=2 -> immediately busy=0, mac_clken=0, out_valid=0, out_data=0, mac_aclr=1. A following start with scenario-1 data -> out_data=64.
